// File: rtl/uart_rx_pkg.sv
// uart_rx_pkg: shared state encoding and widths for the serial RX control path.
package uart_rx_pkg;
    typedef enum logic [2:0] {IDLE, START_CHK, RECEIVE, STOP_CHK, LOAD, ERR_WAIT} rx_state_t;
    localparam int BIT_CNT_W = 4;
endpackage

// File: rtl/rx_sample_timer.sv
// rx_sample_timer: per-bit tick counter giving the half-bit and mid-bit sample ticks.
module rx_sample_timer #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic n_rst,
    input  logic clear,
    input  logic enable,
    output logic half_tick,
    output logic sample_tick
);
    localparam int W    = $clog2(CLKS_PER_BIT);
    localparam int HALF = CLKS_PER_BIT / 2;

    logic [W-1:0] tick_cnt;

    always_ff @(posedge clk)
        if (!n_rst || clear) tick_cnt <= '0;
        else if (enable) tick_cnt <= sample_tick ? '0 : tick_cnt + 1'b1;

    assign half_tick   = tick_cnt == W'(HALF - 1);
    assign sample_tick = tick_cnt == W'(CLKS_PER_BIT - 1);
endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: start detect, mid-bit sampling and frame accept/reject for the RX path.
module uart_rx_ctrl
    import uart_rx_pkg::*;
#(
    parameter int CLKS_PER_BIT  = 10,
    parameter int NUM_DATA_BITS = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 serial_in,
    input  logic                 bit_rollover_flag,
    output logic                 bit_clear,
    output logic                 bit_count_enable,
    output logic [BIT_CNT_W-1:0] bit_rollover_val,
    output logic                 shift_strobe,
    output logic                 load_buffer,
    output logic                 framing_error,
    output logic                 rx_busy
);
    rx_state_t state, next_state;
    logic serial_in_q, stop_bit_q, start_edge, half_tick, raw_tick, sample_tick;

    assign start_edge  = serial_in_q && !serial_in;
    assign sample_tick = (state == RECEIVE) && raw_tick;

    // The START_CHK -> RECEIVE hand-off restarts the count so RECEIVE samples one full bit later.
    rx_sample_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
        .clk        (clk),
        .n_rst      (n_rst),
        .clear      (!(state == START_CHK || state == RECEIVE) || (state == START_CHK && half_tick)),
        .enable     (1'b1),
        .half_tick  (half_tick),
        .sample_tick(raw_tick)
    );

    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = start_edge ? START_CHK : IDLE;
            START_CHK: next_state = !half_tick ? START_CHK : serial_in ? IDLE : RECEIVE;
            RECEIVE:   next_state = bit_rollover_flag ? STOP_CHK : RECEIVE;
            STOP_CHK:  next_state = stop_bit_q ? LOAD : ERR_WAIT;
            LOAD:      next_state = IDLE;
            ERR_WAIT:  next_state = serial_in ? IDLE : ERR_WAIT;
            default:   next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk)
        if (!n_rst) begin
            state         <= IDLE;
            serial_in_q   <= 1'b1;
            stop_bit_q    <= 1'b1;
            framing_error <= 1'b0;
        end else begin
            state       <= next_state;
            serial_in_q <= serial_in;
            if (sample_tick) stop_bit_q <= serial_in;
            if (state == STOP_CHK && !stop_bit_q) framing_error <= 1'b1;
            else if (state == IDLE && start_edge) framing_error <= 1'b0;
        end

    assign bit_clear        = state == IDLE;
    assign rx_busy          = state != IDLE;
    assign load_buffer      = state == LOAD;
    assign shift_strobe     = sample_tick;
    assign bit_count_enable = sample_tick;
    assign bit_rollover_val = BIT_CNT_W'(NUM_DATA_BITS + 1);
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: directed frames with a bit/frame scoreboard and a behavioural bit counter on the bit_* ports.
module tb_uart_rx_ctrl;
    logic clk = 1'b0, n_rst = 1'b0, serial_in = 1'b1;
    logic bit_rollover_flag, bit_clear, bit_count_enable, shift_strobe, load_buffer, framing_error, rx_busy;
    logic [3:0] bit_rollover_val, bit_cnt;
    logic [8:0] sr;
    int cyc = 0, ncmp = 0, nfail = 0, n_strobe = 0, n_en = 0, n_load = 0;
    int s_strobe, s_en, s_load;
    logic       exp_bit_q[$];
    int         exp_cyc_q[$];
    logic [7:0] exp_frame_q[$];

    uart_rx_ctrl #(.CLKS_PER_BIT(10), .NUM_DATA_BITS(8)) dut (
        .clk(clk), .n_rst(n_rst), .serial_in(serial_in), .bit_rollover_flag(bit_rollover_flag),
        .bit_clear(bit_clear), .bit_count_enable(bit_count_enable), .bit_rollover_val(bit_rollover_val),
        .shift_strobe(shift_strobe), .load_buffer(load_buffer), .framing_error(framing_error), .rx_busy(rx_busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Bit counter: wraps after rollover_val, flag registered off the next count.
    always_ff @(posedge clk)
        if (!n_rst || bit_clear) begin
            bit_cnt <= '0;
            bit_rollover_flag <= 1'b0;
        end else if (bit_count_enable) begin
            bit_cnt <= (bit_cnt == bit_rollover_val) ? 4'd1 : bit_cnt + 4'd1;
            bit_rollover_flag <= ((bit_cnt == bit_rollover_val) ? 4'd1 : bit_cnt + 4'd1) == bit_rollover_val;
        end

    always_ff @(posedge clk)
        if (shift_strobe) sr <= {serial_in, sr[8:1]};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (shift_strobe) begin
            n_strobe++;
            chk("strobe_expected", 32'(exp_bit_q.size() > 0), 1);
            if (exp_bit_q.size() > 0) begin
                chk("strobe_bit", serial_in, exp_bit_q.pop_front());
                chk("strobe_cycle", cyc, exp_cyc_q.pop_front());
            end
        end
        if (bit_count_enable) n_en++;
        if (load_buffer) begin
            n_load++;
            chk("load_expected", 32'(exp_frame_q.size() > 0), 1);
            if (exp_frame_q.size() > 0) begin
                chk("load_data", sr[7:0], exp_frame_q.pop_front());
                chk("load_stop", sr[8], 1);
            end
        end
    end

    task automatic snap();
        s_strobe = n_strobe;
        s_en = n_en;
        s_load = n_load;
    endtask

    task automatic wait_bit(input bit chk_fe);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            if (k == 0 && chk_fe) begin
                @(negedge clk);
                chk("fe_clear_at_start", framing_error, 0);
            end
        end
        #1;
    endtask

    // Drives start + 8 data + stop from just after a rising edge; abort_at >= 0 resets at that data bit.
    task automatic send(input logic [7:0] d, input logic stop, input int abort_at, input bit chk_fe);
        int c0 = cyc;
        if (stop && abort_at < 0) exp_frame_q.push_back(d);
        serial_in = 1'b0;
        wait_bit(chk_fe);
        for (int i = 0; i < 9; i++) begin
            if (i == abort_at) begin
                n_rst = 1'b0;
                serial_in = 1'b1;
                @(posedge clk);
                #1 n_rst = 1'b1;
                @(negedge clk);
                chk("abort_busy", rx_busy, 0);
                chk("abort_clear", bit_clear, 1);
                #4;
                return;
            end
            serial_in = (i < 8) ? d[i] : stop;
            exp_bit_q.push_back(serial_in);
            exp_cyc_q.push_back(c0 + 15 + 10 * i);
            wait_bit(1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_bit_clear", bit_clear, 1);
        chk("rst_busy", rx_busy, 0);
        chk("rst_fe", framing_error, 0);
        chk("rst_load", load_buffer, 0);
        chk("rst_strobe", shift_strobe, 0);
        chk("rst_rollover_val", bit_rollover_val, 9);
        @(posedge clk);
        #1 n_rst = 1'b1;
        idle(3);

        snap();
        send(8'hA5, 1'b1, -1, 1'b0);
        @(negedge clk);
        chk("a5_busy", rx_busy, 0);
        chk("a5_fe", framing_error, 0);
        chk("a5_loads", n_load - s_load, 1);
        chk("a5_strobes", n_strobe - s_strobe, 9);
        chk("a5_enables", n_en - s_en, 9);
        idle(5);

        snap();
        serial_in = 1'b0;
        idle(3);
        serial_in = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("glitch_busy_tick4", rx_busy, 1);
        @(negedge clk);
        chk("glitch_idle", rx_busy, 0);
        idle(20);
        chk("glitch_strobes", n_strobe - s_strobe, 0);
        chk("glitch_enables", n_en - s_en, 0);

        snap();
        send(8'h3C, 1'b0, -1, 1'b0);
        idle(20);
        @(negedge clk);
        chk("err_busy_hold", rx_busy, 1);
        chk("err_fe", framing_error, 1);
        chk("err_loads", n_load - s_load, 0);
        chk("err_strobes", n_strobe - s_strobe, 9);
        #4 serial_in = 1'b1;
        @(negedge clk);
        chk("err_release", rx_busy, 0);
        chk("err_fe_sticky", framing_error, 1);
        idle(3);
        snap();
        send(8'h5A, 1'b1, -1, 1'b1);
        idle(3);
        chk("recover_loads", n_load - s_load, 1);

        snap();
        send(8'h6E, 1'b1, 3, 1'b0);
        idle(30);
        chk("abort_loads", n_load - s_load, 0);
        chk("abort_strobes", n_strobe - s_strobe, 3);
        chk("abort_fe", framing_error, 0);
        chk("abort_queue", exp_bit_q.size(), 0);
        snap();
        send(8'h81, 1'b1, -1, 1'b0);
        idle(3);
        chk("81_loads", n_load - s_load, 1);
        chk("81_strobes", n_strobe - s_strobe, 9);

        snap();
        send(8'h00, 1'b1, -1, 1'b0);
        send(8'hFF, 1'b1, -1, 1'b0);
        idle(5);
        chk("b2b_loads", n_load - s_load, 2);
        chk("b2b_strobes", n_strobe - s_strobe, 18);
        chk("b2b_fe", framing_error, 0);
        chk("b2b_busy", rx_busy, 0);

        chk("bits_drained", exp_bit_q.size(), 0);
        chk("frames_drained", exp_frame_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
